// File: rtl/vga_timing_pkg.sv
// Shared VGA timing defaults (640x480 @ 60 Hz) and common types for the
// vga_ctrl slice.
package vga_timing_pkg;

    localparam int unsigned H_SYNC_DEF  = 96;
    localparam int unsigned H_BACK_DEF  = 48;
    localparam int unsigned H_VALID_DEF = 640;
    localparam int unsigned H_FRONT_DEF = 16;
    localparam int unsigned V_SYNC_DEF  = 2;
    localparam int unsigned V_BACK_DEF  = 33;
    localparam int unsigned V_VALID_DEF = 480;
    localparam int unsigned V_FRONT_DEF = 10;

    localparam int unsigned H_TOTAL = H_SYNC_DEF + H_BACK_DEF + H_VALID_DEF + H_FRONT_DEF;
    localparam int unsigned V_TOTAL = V_SYNC_DEF + V_BACK_DEF + V_VALID_DEF + V_FRONT_DEF;

    localparam int unsigned RGB_W = 16;
    localparam int unsigned CNT_W = 10;

    typedef logic [RGB_W-1:0] rgb565_t;
    typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/vga_ctrl_if.sv
// Pixel-fetch handshake between the VGA timing controller (master) and the
// pixel source (slave); data returns the cycle after the request.
interface vga_ctrl_if;
    import vga_timing_pkg::*;

    logic    pix_data_req;
    cnt_t    pix_x;
    cnt_t    pix_y;
    rgb565_t pix_data;

    modport master (
        output pix_data_req,
        output pix_x,
        output pix_y,
        input  pix_data
    );

    modport slave (
        input  pix_data_req,
        input  pix_x,
        input  pix_y,
        output pix_data
    );

endinterface

// File: rtl/vga_ctrl_wrap_counter.sv
// Modulo-N up counter with enable; wrap flags the enabled cycle on which the
// count returns to zero.
module wrap_counter
    import vga_timing_pkg::*;
#(
    parameter int unsigned MODULUS = H_TOTAL,
    parameter int unsigned WIDTH   = CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [WIDTH-1:0] cnt,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

    assign wrap = en && (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= wrap ? '0 : cnt + WIDTH'(1);
        end
    end

endmodule

// File: rtl/vga_ctrl.sv
// VGA timing generator: h/v counters with combinational sync, blanking,
// pixel-request and frame-end decodes.
module vga_ctrl
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_SYNC  = H_SYNC_DEF,
    parameter int unsigned H_BACK  = H_BACK_DEF,
    parameter int unsigned H_VALID = H_VALID_DEF,
    parameter int unsigned H_FRONT = H_FRONT_DEF,
    parameter int unsigned V_SYNC  = V_SYNC_DEF,
    parameter int unsigned V_BACK  = V_BACK_DEF,
    parameter int unsigned V_VALID = V_VALID_DEF,
    parameter int unsigned V_FRONT = V_FRONT_DEF
) (
    input  logic       vga_clk,
    input  logic       sys_rst_n,
    vga_ctrl_if.master pix,
    output logic       hsync,
    output logic       vsync,
    output rgb565_t    rgb,
    output logic       rgb_valid,
    output logic       frame_end
);

    localparam int unsigned H_TOT = H_SYNC + H_BACK + H_VALID + H_FRONT;
    localparam int unsigned V_TOT = V_SYNC + V_BACK + V_VALID + V_FRONT;

    localparam cnt_t H_SYNC_END = CNT_W'(H_SYNC);
    localparam cnt_t V_SYNC_END = CNT_W'(V_SYNC);
    localparam cnt_t H_VIS_BEG  = CNT_W'(H_SYNC + H_BACK);
    localparam cnt_t H_VIS_END  = CNT_W'(H_SYNC + H_BACK + H_VALID - 1);
    localparam cnt_t H_REQ_BEG  = CNT_W'(H_SYNC + H_BACK - 1);
    localparam cnt_t H_REQ_END  = CNT_W'(H_SYNC + H_BACK + H_VALID - 2);
    localparam cnt_t V_VIS_BEG  = CNT_W'(V_SYNC + V_BACK);
    localparam cnt_t V_VIS_END  = CNT_W'(V_SYNC + V_BACK + V_VALID - 1);

    cnt_t h_cnt;
    cnt_t v_cnt;
    logic h_wrap;
    logic v_wrap;
    logic h_vis;
    logic h_req;
    logic v_vis;

    wrap_counter #(.MODULUS(H_TOT), .WIDTH(CNT_W)) u_h_cnt (
        .clk   (vga_clk),
        .rst_n (sys_rst_n),
        .en    (1'b1),
        .cnt   (h_cnt),
        .wrap  (h_wrap)
    );

    wrap_counter #(.MODULUS(V_TOT), .WIDTH(CNT_W)) u_v_cnt (
        .clk   (vga_clk),
        .rst_n (sys_rst_n),
        .en    (h_wrap),
        .cnt   (v_cnt),
        .wrap  (v_wrap)
    );

    // Request window leads the visible window by one cycle to cover the
    // source's one-cycle read latency.
    always_comb begin
        h_vis = (h_cnt >= H_VIS_BEG) && (h_cnt <= H_VIS_END);
        h_req = (h_cnt >= H_REQ_BEG) && (h_cnt <= H_REQ_END);
        v_vis = (v_cnt >= V_VIS_BEG) && (v_cnt <= V_VIS_END);

        hsync            = (h_cnt >= H_SYNC_END);
        vsync            = (v_cnt >= V_SYNC_END);
        rgb_valid        = h_vis && v_vis;
        pix.pix_data_req = h_req && v_vis;
        pix.pix_x        = pix.pix_data_req ? (h_cnt - H_REQ_BEG) : '0;
        pix.pix_y        = pix.pix_data_req ? (v_cnt - V_VIS_BEG) : '0;
        rgb              = rgb_valid ? pix.pix_data : '0;
        frame_end        = v_wrap;
    end

endmodule

// File: tb/tb_vga_ctrl.sv
// Directed bench for vga_ctrl: a default-timing instance for line-level checks
// and a tiny-timing instance for whole-frame and mid-frame reset checks.
module tb_vga_ctrl;
    import vga_timing_pkg::*;

    typedef struct packed {
        logic    hs;
        logic    vs;
        logic    rv;
        logic    req;
        logic    fe;
        cnt_t    x;
        cnt_t    y;
        rgb565_t rgb;
    } obs_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic    rst_d_n, rst_s_n;
    logic    hs_d, vs_d, rv_d, fe_d;
    logic    hs_s, vs_s, rv_s, fe_s;
    rgb565_t rgb_d, rgb_s;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    vga_ctrl_if if_d ();
    vga_ctrl_if if_s ();

    vga_ctrl u_dut_d (
        .vga_clk   (clk),
        .sys_rst_n (rst_d_n),
        .pix       (if_d.master),
        .hsync     (hs_d),
        .vsync     (vs_d),
        .rgb       (rgb_d),
        .rgb_valid (rv_d),
        .frame_end (fe_d)
    );

    vga_ctrl #(
        .H_SYNC (3), .H_BACK (2), .H_VALID (4), .H_FRONT (1),
        .V_SYNC (2), .V_BACK (1), .V_VALID (3), .V_FRONT (1)
    ) u_dut_s (
        .vga_clk   (clk),
        .sys_rst_n (rst_s_n),
        .pix       (if_s.master),
        .hsync     (hs_s),
        .vsync     (vs_s),
        .rgb       (rgb_s),
        .rgb_valid (rv_s),
        .frame_end (fe_s)
    );

    function automatic rgb565_t pat(input cnt_t x, input cnt_t y);
        return {y[4:0], x[5:0], y[4:0]};
    endfunction

    // Expected outputs k rising edges after reset release.
    function automatic obs_t model(input int unsigned k,
                                   input int unsigned hs, input int unsigned hb,
                                   input int unsigned hv, input int unsigned hf,
                                   input int unsigned vs, input int unsigned vb,
                                   input int unsigned vv, input int unsigned vf);
        int unsigned ht = hs + hb + hv + hf;
        int unsigned vt = vs + vb + vv + vf;
        int unsigned h  = k % ht;
        int unsigned v  = (k / ht) % vt;
        logic        vin;
        obs_t        e;
        e      = '0;
        vin    = (v >= vs + vb) && (v < vs + vb + vv);
        e.hs   = (h >= hs);
        e.vs   = (v >= vs);
        e.rv   = vin && (h >= hs + hb) && (h < hs + hb + hv);
        e.req  = vin && (h + 1 >= hs + hb) && (h + 1 < hs + hb + hv);
        e.fe   = (h == ht - 1) && (v == vt - 1);
        if (e.req) begin
            e.x = cnt_t'(h + 1 - (hs + hb));
            e.y = cnt_t'(v - (vs + vb));
        end
        if (e.rv) e.rgb = pat(cnt_t'(h - (hs + hb)), cnt_t'(v - (vs + vb)));
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pixel sources: answer each request one cycle later, garbage otherwise.
    initial begin : src_d
        logic r;
        cnt_t x, y;
        if_d.pix_data = 16'hDEAD;
        forever begin
            @(negedge clk);
            r = if_d.pix_data_req; x = if_d.pix_x; y = if_d.pix_y;
            @(posedge clk); #1;
            if_d.pix_data = r ? pat(x, y) : 16'hDEAD;
        end
    end

    initial begin : src_s
        logic r;
        cnt_t x, y;
        if_s.pix_data = 16'hBEEF;
        forever begin
            @(negedge clk);
            r = if_s.pix_data_req; x = if_s.pix_x; y = if_s.pix_y;
            @(posedge clk); #1;
            if_s.pix_data = r ? pat(x, y) : 16'hBEEF;
        end
    end

    initial begin : stim
        obs_t        od, os;
        int unsigned bad_d = 0, bad_s = 0, leak_d = 0;
        int          first_rise = -1, last_rise = -1, vs_first = -1;
        int unsigned hs_low = 0;
        logic        hs_prev = 1'b0;
        int          first_req = -1, last_req = -1;
        int unsigned fx = 0, fy = 0, lx = 0, nreq = 0, nvalid = 0, rgb_ok = 0;
        int          fe1 = -1, fe2 = -1, fe_after = -1;
        int unsigned nfe = 0, ymax = 0, xmax = 0, ks;
        cnt_t        xx;

        rst_d_n = 1'b0;
        rst_s_n = 1'b0;
        #3;
        chk("rst_hsync",     hs_d, 0);
        chk("rst_vsync",     vs_d, 0);
        chk("rst_rgb",       rgb_d, 0);
        chk("rst_rgb_valid", rv_d, 0);
        chk("rst_req",       if_d.pix_data_req, 0);
        chk("rst_pix_x",     if_d.pix_x, 0);
        chk("rst_pix_y",     if_d.pix_y, 0);
        chk("rst_frame_end", fe_d, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        os = {hs_s, vs_s, rv_s, if_s.pix_data_req, fe_s, if_s.pix_x, if_s.pix_y, rgb_s};
        chk("rst_held_small", os, 0);
        rst_d_n = 1'b1;
        rst_s_n = 1'b1;
        #1;
        od = {hs_d, vs_d, rv_d, if_d.pix_data_req, fe_d, if_d.pix_x, if_d.pix_y, rgb_d};
        chk("released_k0", od, 0);

        for (int unsigned k = 1; k <= 28800; k++) begin
            @(posedge clk);
            @(negedge clk);
            od = {hs_d, vs_d, rv_d, if_d.pix_data_req, fe_d, if_d.pix_x, if_d.pix_y, rgb_d};
            os = {hs_s, vs_s, rv_s, if_s.pix_data_req, fe_s, if_s.pix_x, if_s.pix_y, rgb_s};
            if (od !== model(k, 96, 48, 640, 16, 2, 33, 480, 10)) bad_d++;
            if (os !== model(k, 3, 2, 4, 1, 2, 1, 3, 1)) bad_s++;

            if (hs_d && !hs_prev) begin
                if (first_rise < 0) first_rise = int'(k);
                if (k <= 2400) last_rise = int'(k);
            end
            hs_prev = hs_d;
            if (k >= 800 && k < 3200 && !hs_d) hs_low++;
            if (vs_d && vs_first < 0) vs_first = int'(k);

            if (if_d.pix_data_req) begin
                if (first_req < 0) begin
                    first_req = int'(k); fx = if_d.pix_x; fy = if_d.pix_y;
                end
                last_req = int'(k); lx = if_d.pix_x; nreq++;
            end
            if (rv_d) begin
                nvalid++;
                xx = cnt_t'(k - 28144);
                if (rgb_d === {5'd0, xx[5:0], 5'd0}) rgb_ok++;
            end else if (rgb_d !== 16'h0000) begin
                leak_d++;
            end

            if (k <= 140 && fe_s) begin
                nfe++;
                if (nfe == 1) fe1 = int'(k);
                if (nfe == 2) fe2 = int'(k);
            end
            if (if_s.pix_data_req) begin
                if (if_s.pix_y > ymax) ymax = if_s.pix_y;
                if (if_s.pix_x > xmax) xmax = if_s.pix_x;
            end
        end

        chk("hsync_first_rise", first_rise, 96);
        chk("hsync_low_3lines", hs_low, 288);
        chk("hsync_rise_line2", last_rise, 1696);
        chk("vsync_first_high", vs_first, 1600);
        chk("req_first_cycle",  first_req, 28143);
        chk("req_first_x",      fx, 0);
        chk("req_first_y",      fy, 0);
        chk("req_last_cycle",   last_req, 28782);
        chk("req_last_x",       lx, 639);
        chk("req_count_line",   nreq, 640);
        chk("valid_count_line", nvalid, 640);
        chk("rgb_match_line",   rgb_ok, 640);
        chk("rgb_blank_leak",   leak_d, 0);
        chk("model_default",    bad_d, 0);
        chk("model_small",      bad_s, 0);
        chk("fe_first",         fe1, 69);
        chk("fe_second",        fe2, 139);
        chk("fe_count_2frames", nfe, 2);
        chk("small_last_row_y", ymax, 2);
        chk("small_last_col_x", xmax, 3);

        // Walk the small instance to h=6, v=4 (inside the visible area).
        ks = 28800;
        for (int unsigned n = 0; n < 100 && (ks % 70) != 46; n++) begin
            @(posedge clk);
            @(negedge clk);
            ks++;
        end
        chk("pre_rst_position", ks % 70, 46);
        chk("pre_rst_hsync",    hs_s, 1);
        chk("pre_rst_valid",    rv_s, 1);
        #1 rst_s_n = 1'b0;
        #1;
        os = {hs_s, vs_s, rv_s, if_s.pix_data_req, fe_s, if_s.pix_x, if_s.pix_y, rgb_s};
        chk("rst_async_small",  os, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_s_n = 1'b1;
        for (int n = 1; n <= 200; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (fe_s) begin
                fe_after = n;
                break;
            end
        end
        chk("fe_after_rst", fe_after, 69);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
